// File: rtl/dfx_scan_chain_ctl_pkg.sv
// Shared definitions for the scan chain controller: FSM encoding and the default inversion mask.
package dfx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_CAPTURE,
        ST_SHIFT_OUT,
        ST_DONE
    } dfxState_t;

    localparam int MAX_WIDTH = 64;

    // Every cell except cell 0 inverts its functional input.
    function automatic logic [MAX_WIDTH-1:0] defaultInvMask(input int width);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int k = 1; k < width && k < MAX_WIDTH; k++) m[k] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/dfx_scan_chain_ctl_if.sv
// Test-access and chain-observation signals of the scan chain controller.
interface dfx_scan_chain_ctl_if #(
    parameter int WIDTH = 8
);
    logic             rD;
    logic             rSE;
    logic             rSD;
    logic             rStart;
    logic [WIDTH-1:0] rPattern;
    logic [WIDTH-1:0] rExpect;
    logic [WIDTH-1:0] rQ;
    logic             rSO;
    logic             rBusy;
    logic             rDone;
    logic             rPass;
    logic [WIDTH-1:0] rCapture;

    modport master (
        output rD, rSE, rSD, rStart, rPattern, rExpect,
        input  rQ, rSO, rBusy, rDone, rPass, rCapture
    );

    modport slave (
        input  rD, rSE, rSD, rStart, rPattern, rExpect,
        output rQ, rSO, rBusy, rDone, rPass, rCapture
    );
endinterface

// File: rtl/dfx_scan_chain_ctl_cell.sv
// Single mux-D scan flop: SE selects scan-in over functional D; one-cycle latency.
module dfx_scan_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic SE,
    input  logic SD,
    input  logic D,
    output logic Q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) Q <= 1'b0;
        else        Q <= SE ? SD : D;
    end
endmodule

// File: rtl/dfx_scan_chain_ctl.sv
// WIDTH-cell scan chain with a load/capture/unload test controller; a full auto test takes 2*WIDTH+2 cycles.
// External scan and start requests are ignored while a test is running.
module dfx_scan_chain_ctl
    import dfx_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INV_MASK = WIDTH'(defaultInvMask(WIDTH))
) (
    input logic                 rclk,
    input logic                 rrst_n,
    dfx_scan_chain_ctl_if.slave bus
);
    localparam int             CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    dfxState_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] patLat;
    logic [WIDTH-1:0] expLat;
    logic [WIDTH-1:0] capture;
    logic             pass;
    logic             done;
    logic             busy;
    logic             soQ;

    logic [WIDTH-1:0] chainQ;
    logic [WIDTH-1:0] funcD;
    logic [WIDTH-1:0] scanD;
    logic             chainSE;
    logic             chainSD;

    assign funcD = {chainQ[WIDTH-2:0], bus.rD} ^ INV_MASK;
    assign scanD = {chainQ[WIDTH-2:0], chainSD};

    for (genvar k = 0; k < WIDTH; k++) begin : gCell
        dfx_scan_cell uCell (
            .clk   (rclk),
            .rst_n (rrst_n),
            .SE    (chainSE),
            .SD    (scanD[k]),
            .D     (funcD[k]),
            .Q     (chainQ[k])
        );
    end

    // Outside IDLE the chain keeps shifting zeros except for the single capture cycle.
    always_comb begin
        chainSE = 1'b1;
        chainSD = 1'b0;
        case (state)
            ST_IDLE: begin
                chainSE = bus.rSE;
                chainSD = bus.rSD;
            end
            ST_SHIFT_IN: chainSD = patLat[WIDTH-1];
            ST_CAPTURE:  chainSE = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            patLat  <= '0;
            expLat  <= '0;
            capture <= '0;
            pass    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            soQ     <= 1'b0;
        end else begin
            soQ  <= chainQ[WIDTH-1];
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rStart) begin
                        patLat <= bus.rPattern;
                        expLat <= bus.rExpect;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT_IN;
                    end
                end
                ST_SHIFT_IN: begin
                    // Pattern copy shifts left so its MSB always feeds the chain next.
                    patLat <= patLat << 1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    capture <= funcD;
                    pass    <= (funcD == expLat);
                    state   <= ST_SHIFT_OUT;
                end
                ST_SHIFT_OUT: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rQ       = chainQ;
    assign bus.rSO      = soQ;
    assign bus.rBusy    = busy;
    assign bus.rDone    = done;
    assign bus.rPass    = pass;
    assign bus.rCapture = capture;
endmodule

// File: tb/tb_dfx_scan_chain_ctl.sv
// Directed bench for dfx_scan_chain_ctl with a cycle-level reference model and literal spot checks.
module tb_dfx_scan_chain_ctl;
    localparam int             W   = 8;
    localparam logic [W-1:0]   INV = 8'hFE;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;
    always #5 rclk = ~rclk;

    dfx_scan_chain_ctl_if #(.WIDTH(W)) bus ();
    dfx_scan_chain_ctl #(.WIDTH(W)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    int tests   = 0;
    int fails   = 0;
    int doneCnt = 0;
    bit checkOn = 1'b0;

    // Reference model: an auto test is a timeline of edges counted from the accepting edge.
    logic [W-1:0] mQ = '0, mCap = '0, mPat = '0, mExp = '0, prevQ;
    logic         mSO = 1'b0, mBusy = 1'b0, mDone = 1'b0, mPass = 1'b0;
    int           age = 0;

    function automatic logic [W-1:0] funcNext(input logic [W-1:0] q, input logic d);
        return {q[W-2:0], d} ^ INV;
    endfunction

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            mQ = '0; mCap = '0; mPat = '0; mExp = '0;
            mSO = 1'b0; mBusy = 1'b0; mDone = 1'b0; mPass = 1'b0; age = 0;
        end else begin
            prevQ = mQ;
            mSO   = prevQ[W-1];
            mDone = 1'b0;
            if (age == 0) begin
                mQ = bus.rSE ? {prevQ[W-2:0], bus.rSD} : funcNext(prevQ, bus.rD);
                if (bus.rStart) begin
                    mPat = bus.rPattern; mExp = bus.rExpect; mBusy = 1'b1; age = 1;
                end
            end else begin
                if (age <= W)          mQ = {prevQ[W-2:0], mPat[W-age]};
                else if (age == W + 1) begin
                    mQ = funcNext(prevQ, bus.rD); mCap = mQ; mPass = (mQ == mExp);
                end else               mQ = {prevQ[W-2:0], 1'b0};
                if (age == 2*W + 1) mDone = 1'b1;
                if (age == 2*W + 2) begin age = 0; mBusy = 1'b0; end
                else                age++;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rclk) begin
        if (checkOn) begin
            check("model_rQ",       bus.rQ,       mQ);
            check("model_rSO",      W'(bus.rSO),  W'(mSO));
            check("model_rBusy",    W'(bus.rBusy), W'(mBusy));
            check("model_rDone",    W'(bus.rDone), W'(mDone));
            check("model_rPass",    W'(bus.rPass), W'(mPass));
            check("model_rCapture", bus.rCapture, mCap);
            if (bus.rDone === 1'b1) doneCnt++;
        end
    end

    task automatic step();
        @(posedge rclk);
        #2;
    endtask

    // Runs one auto test from the next edge (edge 0); returns the edge after which rDone was seen
    // and the rSO values observed after edges 10..17.
    task automatic runAuto(input logic [W-1:0] pat, input logic [W-1:0] exp,
                           input logic se, input logic sd, input bit keep,
                           output int doneEdge, output logic [W-1:0] soStream);
        bus.rD = 1'b0; bus.rSE = se; bus.rSD = sd;
        bus.rPattern = pat; bus.rExpect = exp; bus.rStart = 1'b1;
        step();
        if (!keep) bus.rStart = 1'b0;
        doneEdge = -1;
        soStream = '0;
        for (int e = 1; e <= 40 && doneEdge < 0; e++) begin
            @(posedge rclk);
            @(negedge rclk);
            if (e >= W + 2 && e <= 2*W + 1) soStream = {soStream[W-2:0], bus.rSO};
            if (bus.rDone === 1'b1) doneEdge = e;
        end
    endtask

    logic [W-1:0] bits, so;
    int           dEdge, d0;

    initial begin
        bus.rD = 1'b0; bus.rSE = 1'b0; bus.rSD = 1'b0; bus.rStart = 1'b0;
        bus.rPattern = '0; bus.rExpect = '0;
        repeat (3) @(posedge rclk);
        #2 rrst_n = 1'b1;
        checkOn = 1'b1;
        @(negedge rclk);
        check("reset_rQ", bus.rQ, 8'h00);
        check("reset_rBusy", W'(bus.rBusy), 8'h00);
        check("reset_rCapture", bus.rCapture, 8'h00);

        // Manual scan shift
        bits = 8'b1011_0010;
        bus.rSE = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            bus.rSD = bits[i];
            step();
        end
        @(negedge rclk);
        check("manual_rQ", bus.rQ, 8'hB2);
        bus.rSD = 1'b0;
        step();
        @(negedge rclk);
        check("manual_rSO_lag", W'(bus.rSO), 8'h01);
        repeat (W - 1) step();

        // Functional ripple from an all-zero chain
        bus.rSE = 1'b0; bus.rD = 1'b1;
        step();
        @(negedge rclk);
        check("func_first", bus.rQ, 8'hFF);
        step();
        @(negedge rclk);
        check("func_second", bus.rQ, 8'h01);

        // Auto test, passing
        runAuto(8'h55, 8'h54, 1'b0, 1'b0, 1'b0, dEdge, so);
        checkInt("pass_done_edge", dEdge, 17);
        check("pass_rCapture", bus.rCapture, 8'h54);
        check("pass_rPass", W'(bus.rPass), 8'h01);
        check("pass_so_stream", so, 8'b0101_0100);
        repeat (2) step();

        // Auto test, failing
        runAuto(8'h55, 8'h55, 1'b0, 1'b0, 1'b0, dEdge, so);
        checkInt("fail_done_edge", dEdge, 17);
        check("fail_rCapture", bus.rCapture, 8'h54);
        check("fail_rPass", W'(bus.rPass), 8'h00);
        repeat (2) step();

        // Start, SE and SD held high through a whole test
        runAuto(8'hA3, 8'hB8, 1'b1, 1'b1, 1'b1, dEdge, so);
        checkInt("busy_done_edge", dEdge, 17);
        check("busy_rCapture", bus.rCapture, 8'hB8);
        check("busy_rPass", W'(bus.rPass), 8'h01);
        @(posedge rclk);
        @(negedge rclk);
        check("busy_idle_gap", W'(bus.rBusy), 8'h00);
        @(posedge rclk);
        @(negedge rclk);
        check("busy_restart", W'(bus.rBusy), 8'h01);
        bus.rStart = 1'b0; bus.rSE = 1'b0; bus.rSD = 1'b0;
        dEdge = -1;
        for (int c = 0; c < 40 && dEdge < 0; c++) begin
            @(negedge rclk);
            if (bus.rDone === 1'b1) dEdge = c;
        end
        tests++;
        if (dEdge < 0) begin
            fails++;
            $display("FAIL busy_second_done: got none expected pulse within 40 cycles");
        end
        repeat (2) step();

        // Reset during SHIFT_IN with counter at 3
        bus.rPattern = 8'h3C; bus.rExpect = 8'h00; bus.rStart = 1'b1; bus.rSE = 1'b0; bus.rD = 1'b0;
        step();
        bus.rStart = 1'b0;
        repeat (3) @(posedge rclk);
        #2 rrst_n = 1'b0;
        @(negedge rclk);
        check("rst_rQ", bus.rQ, 8'h00);
        check("rst_rBusy", W'(bus.rBusy), 8'h00);
        check("rst_rCapture", bus.rCapture, 8'h00);
        check("rst_rPass", W'(bus.rPass), 8'h00);
        check("rst_rSO", W'(bus.rSO), 8'h00);
        d0 = doneCnt;
        step();
        rrst_n = 1'b1;
        repeat (30) @(negedge rclk);
        checkInt("rst_no_done", doneCnt - d0, 0);
        check("rst_idle_after", W'(bus.rBusy), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
